// File: rtl/pulse_scheduler_mc_pkg.sv
// Shared defaults, channel state encoding and the wrap-safe start-time helper
// for the multi-channel pulse scheduler.
package pulse_sched_pkg;

    localparam int unsigned DEF_NUM_CH     = 4;
    localparam int unsigned DEF_DEPTH      = 8;
    localparam int unsigned DEF_TIME_W     = 32;
    localparam int unsigned DEF_TLEN_W     = 16;
    localparam int unsigned DEF_FREQ_W     = 16;
    localparam int unsigned DEF_PHASE_W    = 16;
    localparam int unsigned DEF_AMP_W      = 16;
    localparam int unsigned DEF_ENV_ADDR_W = 10;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } ch_state_e;

    // diff = t_start - counter truncated to width bits; negative means already missed.
    function automatic logic late_diff(input logic [63:0] diff, input int unsigned width);
        return diff[6'(width - 1)];
    endfunction

endpackage

// File: rtl/pulse_scheduler_mc_if.sv
// Descriptor input bus from the pulse decoder into the scheduler.
interface pulse_scheduler_mc_if #(
    parameter int unsigned CH_W       = 2,
    parameter int unsigned FREQ_W     = 16,
    parameter int unsigned PHASE_W    = 16,
    parameter int unsigned AMP_W      = 16,
    parameter int unsigned TIME_W     = 32,
    parameter int unsigned TLEN_W     = 16,
    parameter int unsigned ENV_ADDR_W = 10
);
    logic                  in_valid;
    logic                  in_ready;
    logic [CH_W-1:0]       in_ch;
    logic [FREQ_W-1:0]     in_freq;
    logic [PHASE_W-1:0]    in_phase;
    logic [AMP_W-1:0]      in_amp;
    logic [TIME_W-1:0]     in_tstart;
    logic [TLEN_W-1:0]     in_tlen;
    logic [ENV_ADDR_W-1:0] in_env_addr;

    modport master (
        output in_valid, in_ch, in_freq, in_phase, in_amp, in_tstart, in_tlen, in_env_addr,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_ch, in_freq, in_phase, in_amp, in_tstart, in_tlen, in_env_addr,
        output in_ready
    );
endinterface

// File: rtl/pulse_scheduler_mc_channel.sv
// One scheduler channel: show-ahead descriptor FIFO, IDLE/ACTIVE FSM and
// registered pulse parameter / envelope address outputs.
module pulse_sched_channel
    import pulse_sched_pkg::*;
#(
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned TIME_W     = DEF_TIME_W,
    parameter int unsigned TLEN_W     = DEF_TLEN_W,
    parameter int unsigned FREQ_W     = DEF_FREQ_W,
    parameter int unsigned PHASE_W    = DEF_PHASE_W,
    parameter int unsigned AMP_W      = DEF_AMP_W,
    parameter int unsigned ENV_ADDR_W = DEF_ENV_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [TIME_W-1:0]     counter_i,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic [FREQ_W-1:0]     freq_i,
    input  logic [PHASE_W-1:0]    phase_i,
    input  logic [AMP_W-1:0]      amp_i,
    input  logic [TIME_W-1:0]     tstart_i,
    input  logic [TLEN_W-1:0]     tlen_i,
    input  logic [ENV_ADDR_W-1:0] env_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  active_o,
    output logic                  start_o,
    output logic [FREQ_W-1:0]     freq_o,
    output logic [PHASE_W-1:0]    phase_o,
    output logic [AMP_W-1:0]      amp_o,
    output logic [ENV_ADDR_W-1:0] env_addr_o,
    output logic                  late_err_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

    logic [FREQ_W-1:0]     freq_mem   [DEPTH];
    logic [PHASE_W-1:0]    phase_mem  [DEPTH];
    logic [AMP_W-1:0]      amp_mem    [DEPTH];
    logic [TIME_W-1:0]     tstart_mem [DEPTH];
    logic [TLEN_W-1:0]     tlen_mem   [DEPTH];
    logic [ENV_ADDR_W-1:0] env_mem    [DEPTH];

    logic [PTR_W:0]        wptr_q, rptr_q;
    ch_state_e             state_q;
    logic [TLEN_W-1:0]     remaining_q;
    logic [ENV_ADDR_W-1:0] env_q;
    logic [FREQ_W-1:0]     freq_q;
    logic [PHASE_W-1:0]    phase_q;
    logic [AMP_W-1:0]      amp_q;
    logic                  start_q, late_q;

    logic [PTR_W-1:0]      rd_idx, wr_idx;
    logic [TIME_W-1:0]     diff_d;
    logic                  can_take_d, pop_d, fire_d, drop_d;

    assign rd_idx  = rptr_q[PTR_W-1:0];
    assign wr_idx  = wptr_q[PTR_W-1:0];
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[PTR_W] != rptr_q[PTR_W]) && (wr_idx == rd_idx);

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            freq_mem[wr_idx]   <= freq_i;
            phase_mem[wr_idx]  <= phase_i;
            amp_mem[wr_idx]    <= amp_i;
            tstart_mem[wr_idx] <= tstart_i;
            tlen_mem[wr_idx]   <= tlen_i;
            env_mem[wr_idx]    <= env_i;
        end
    end

    // Head is examined once per cycle: late, overlap and zero-length all pop without firing.
    always_comb begin
        diff_d     = tstart_mem[rd_idx] - counter_i;
        can_take_d = (state_q == IDLE) || (remaining_q == TLEN_W'(1));
        pop_d      = 1'b0;
        fire_d     = 1'b0;
        drop_d     = 1'b0;
        if (!empty_o) begin
            if (late_diff(64'(diff_d), TIME_W)) begin
                pop_d  = 1'b1;
                drop_d = 1'b1;
            end else if (diff_d == '0) begin
                pop_d = 1'b1;
                if (!can_take_d)
                    drop_d = 1'b1;
                else if (tlen_mem[rd_idx] != '0)
                    fire_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            state_q     <= IDLE;
            remaining_q <= '0;
            env_q       <= '0;
            freq_q      <= '0;
            phase_q     <= '0;
            amp_q       <= '0;
            start_q     <= 1'b0;
            late_q      <= 1'b0;
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            state_q <= IDLE;
            start_q <= 1'b0;
            late_q  <= 1'b0;
        end else begin
            if (push_i) wptr_q <= wptr_q + PTR_ONE;
            if (pop_d)  rptr_q <= rptr_q + PTR_ONE;
            if (drop_d) late_q <= 1'b1;
            start_q <= fire_d;
            if (fire_d) begin
                state_q     <= ACTIVE;
                remaining_q <= tlen_mem[rd_idx];
                env_q       <= env_mem[rd_idx];
                freq_q      <= freq_mem[rd_idx];
                phase_q     <= phase_mem[rd_idx];
                amp_q       <= amp_mem[rd_idx];
            end else if (state_q == ACTIVE) begin
                if (remaining_q == TLEN_W'(1)) begin
                    state_q <= IDLE;
                end else begin
                    remaining_q <= remaining_q - TLEN_W'(1);
                    env_q       <= env_q + ENV_ADDR_W'(1);
                end
            end
        end
    end

    assign active_o   = (state_q == ACTIVE);
    assign start_o    = start_q;
    assign freq_o     = freq_q;
    assign phase_o    = phase_q;
    assign amp_o      = amp_q;
    assign env_addr_o = env_q;
    assign late_err_o = late_q;

endmodule

// File: rtl/pulse_scheduler_mc.sv
// Multi-channel pulse scheduler top: shared timebase, channel decode and
// NUM_CH scheduler channels with packed outputs (channel 0 in the LSBs).
module pulse_scheduler_mc
    import pulse_sched_pkg::*;
#(
    parameter int unsigned NUM_CH     = DEF_NUM_CH,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned TIME_W     = DEF_TIME_W,
    parameter int unsigned TLEN_W     = DEF_TLEN_W,
    parameter int unsigned FREQ_W     = DEF_FREQ_W,
    parameter int unsigned PHASE_W    = DEF_PHASE_W,
    parameter int unsigned AMP_W      = DEF_AMP_W,
    parameter int unsigned ENV_ADDR_W = DEF_ENV_ADDR_W
) (
    input  logic                             clk,
    input  logic                             rst_n,
    pulse_scheduler_mc_if.slave              in_if,
    input  logic                             counter_clear,
    input  logic                             flush,
    output logic [TIME_W-1:0]                counter,
    output logic [NUM_CH-1:0]                pulse_active,
    output logic [NUM_CH-1:0]                pulse_start,
    output logic [NUM_CH*FREQ_W-1:0]         pulse_freq,
    output logic [NUM_CH*PHASE_W-1:0]        pulse_phase,
    output logic [NUM_CH*AMP_W-1:0]          pulse_amp,
    output logic [NUM_CH*ENV_ADDR_W-1:0]     pulse_env_addr,
    output logic [NUM_CH-1:0]                fifo_full,
    output logic [NUM_CH-1:0]                fifo_empty,
    output logic [NUM_CH-1:0]                late_err
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [TIME_W-1:0] counter_q;
    logic              in_ready_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             counter_q <= '0;
        else if (counter_clear) counter_q <= '0;
        else                    counter_q <= counter_q + TIME_W'(1);
    end

    assign counter = counter_q;

    // Out-of-range channel numbers match no channel, so they are never ready.
    always_comb begin
        in_ready_d = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (in_if.in_ch == CH_W'(i)) in_ready_d = !fifo_full[i];
        end
    end

    assign in_if.in_ready = in_ready_d;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pulse_sched_channel #(
            .DEPTH      (DEPTH),
            .TIME_W     (TIME_W),
            .TLEN_W     (TLEN_W),
            .FREQ_W     (FREQ_W),
            .PHASE_W    (PHASE_W),
            .AMP_W      (AMP_W),
            .ENV_ADDR_W (ENV_ADDR_W)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .counter_i  (counter_q),
            .flush_i    (flush),
            .push_i     (in_if.in_valid && in_ready_d && (in_if.in_ch == CH_W'(g))),
            .freq_i     (in_if.in_freq),
            .phase_i    (in_if.in_phase),
            .amp_i      (in_if.in_amp),
            .tstart_i   (in_if.in_tstart),
            .tlen_i     (in_if.in_tlen),
            .env_i      (in_if.in_env_addr),
            .full_o     (fifo_full[g]),
            .empty_o    (fifo_empty[g]),
            .active_o   (pulse_active[g]),
            .start_o    (pulse_start[g]),
            .freq_o     (pulse_freq[g*FREQ_W +: FREQ_W]),
            .phase_o    (pulse_phase[g*PHASE_W +: PHASE_W]),
            .amp_o      (pulse_amp[g*AMP_W +: AMP_W]),
            .env_addr_o (pulse_env_addr[g*ENV_ADDR_W +: ENV_ADDR_W]),
            .late_err_o (late_err[g])
        );
    end

endmodule
